unidade_mult_div: RTL and testbench

- Iterative multiply/divide unit with HI/LO result registers for the simple MIPS processor.
- Sits directly downstream of `banco_registradores`:
  - consumes `valor_reg1` and `valor_reg2` as operands;
  - executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over multiple cycles with a start/busy/done handshake;
  - presents HI/LO continuously so the write-back mux can implement MFHI/MFLO.

---
 rtl/unidade_mult_div.sv | 186 ++++++++++++++++++
 tb/tb_unidade_mult_div.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_mult_div.sv
// Iterative multiply/divide unit with HI/LO registers.
// One shift/add or restoring shift/subtract step per cycle.
module unidade_mult_div #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               inicio,
    input  logic [2:0]         operacao,
    input  logic [LARGURA-1:0] operando_a,
    input  logic [LARGURA-1:0] operando_b,
    output logic               ocupado,
    output logic               pronto,
    output logic               div_por_zero,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);

    localparam int CW = $clog2(LARGURA);
    localparam int L  = LARGURA;

    typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTA} estado_t;

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cont_q, cont_d;
    logic [L-1:0]   acc_q, acc_d;
    logic [L-1:0]   q_q, q_d;
    logic [L-1:0]   m_q, m_d;
    logic [L-1:0]   a_q, a_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic [1:0]     op_q, op_d;
    logic [L-1:0]   hi_q, hi_d;
    logic [L-1:0]   lo_q, lo_d;
    logic           ocup_q, ocup_d;
    logic           pronto_q, pronto_d;
    logic           dz_q, dz_d;

    logic           aceita, ini_md, ini_mt, ultimo;
    logic           neg_a, neg_b;
    logic [L-1:0]   abs_a, abs_b;
    logic [L:0]     soma;
    logic [L:0]     desl;
    logic [L+1:0]   dif;
    logic [2*L-1:0] prod, prod_c;
    logic [L-1:0]   quo_c, rem_c;

    assign aceita = inicio && (estado_q == OCIOSO);
    assign ini_md = aceita && !operacao[2];
    assign ini_mt = aceita && operacao[2] && !operacao[1];
    assign ultimo = (cont_q == CW'(L - 1));

    assign neg_a = operacao[0] && operando_a[L-1];
    assign neg_b = operacao[0] && operando_b[L-1];
    assign abs_a = neg_a ? -operando_a : operando_a;
    assign abs_b = neg_b ? -operando_b : operando_b;

    assign soma = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : '0)};
    assign desl = {acc_q, q_q[L-1]};
    assign dif  = {1'b0, desl} - {2'b00, m_q};

    // Signed results: product/quotient follow sign xor, remainder the dividend.
    assign prod   = {acc_q, q_q};
    assign prod_c = (op_q[0] && (sa_q ^ sb_q)) ? -prod : prod;
    assign quo_c  = (op_q[0] && (sa_q ^ sb_q)) ? -q_q : q_q;
    assign rem_c  = (op_q[0] && sa_q) ? -acc_q : acc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO:  if (ini_md) estado_d = CALCULA;
            CALCULA: if (ultimo) estado_d = AJUSTA;
            AJUSTA:  estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        ocup_d   = (estado_d != OCIOSO);
        pronto_d = (estado_q == AJUSTA) || ini_mt;
    end

    always_comb begin
        cont_d = cont_q;
        acc_d  = acc_q;
        q_d    = q_q;
        m_d    = m_q;
        a_d    = a_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        op_d   = op_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        unique case (estado_q)
            OCIOSO: begin
                if (ini_md) begin
                    op_d   = operacao[1:0];
                    sa_d   = neg_a;
                    sb_d   = neg_b;
                    a_d    = operando_a;
                    cont_d = '0;
                    acc_d  = '0;
                    dz_d   = 1'b0;
                    q_d    = operacao[1] ? abs_a : abs_b;
                    m_d    = operacao[1] ? abs_b : abs_a;
                end else if (ini_mt) begin
                    if (operacao[0]) lo_d = operando_a;
                    else             hi_d = operando_a;
                end
            end
            CALCULA: begin
                cont_d = cont_q + CW'(1);
                if (op_q[1]) begin
                    acc_d = dif[L+1] ? desl[L-1:0] : dif[L-1:0];
                    q_d   = {q_q[L-2:0], ~dif[L+1]};
                end else begin
                    acc_d = soma[L:1];
                    q_d   = {soma[0], q_q[L-1:1]};
                end
            end
            AJUSTA: begin
                cont_d = '0;
                if (!op_q[1]) begin
                    hi_d = prod_c[2*L-1:L];
                    lo_d = prod_c[L-1:0];
                end else if (m_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = rem_c;
                    lo_d = quo_c;
                end
            end
            default: cont_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_q   <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            op_q     <= 2'b00;
            hi_q     <= '0;
            lo_q     <= '0;
            ocup_q   <= 1'b0;
            pronto_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            cont_q   <= cont_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            a_q      <= a_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ocup_q   <= ocup_d;
            pronto_q <= pronto_d;
            dz_q     <= dz_d;
        end
    end

    assign ocupado      = ocup_q;
    assign pronto       = pronto_q;
    assign div_por_zero = dz_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed-vector bench for unidade_mult_div.
// Expected values are hand-computed constants.
module tb_unidade_mult_div;

    logic        clock;
    logic        reset_n;
    logic        inicio;
    logic [2:0]  operacao;
    logic [31:0] operando_a;
    logic [31:0] operando_b;
    logic        ocupado;
    logic        pronto;
    logic        div_por_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_err = 0;

    unidade_mult_div #(.LARGURA(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .inicio       (inicio),
        .operacao     (operacao),
        .operando_a   (operando_a),
        .operando_b   (operando_b),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .div_por_zero (div_por_zero),
        .hi           (hi),
        .lo           (lo)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges until pronto is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (pronto) break;
        end
        chk("done_seen", {63'b0, pronto}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
        int n;
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = op;
        operando_a = a;
        operando_b = b;
        @(posedge clock);
        #1;
        inicio     = 1'b0;
        operando_a = $urandom;
        operando_b = $urandom;
        chk({tag, "_busy"}, {63'b0, ocupado}, 64'd1);
        wait_done(n);
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_hi"}, {32'b0, hi}, {32'b0, e_hi});
        chk({tag, "_lo"}, {32'b0, lo}, {32'b0, e_lo});
        chk({tag, "_idle"}, {63'b0, ocupado}, 64'd0);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, {63'b0, pronto}, 64'd0);
    endtask

    task automatic mtx(input logic op_lo, input logic [31:0] v);
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = {2'b10, op_lo};
        operando_a = v;
        @(posedge clock);
        #1;
        inicio = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] lo_prev;
        logic [31:0] hi_prev;

        reset_n    = 1'b0;
        inicio     = 1'b0;
        operacao   = 3'b000;
        operando_a = '0;
        operando_b = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, ocupado}, 64'd0);
        chk("rst_pronto", {63'b0, pronto}, 64'd0);
        chk("rst_dz", {63'b0, div_por_zero}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset in the middle of an operation
        mtx(1'b0, 32'h0000_0055);
        mtx(1'b1, 32'h0000_0066);
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = 3'b000;
        operando_a = 32'd3;
        operando_b = 32'd5;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_hi", {32'b0, hi}, 64'd0);
        chk("mrst_lo", {32'b0, lo}, 64'd0);
        chk("mrst_busy", {63'b0, ocupado}, 64'd0);
        chk("mrst_pronto", {63'b0, pronto}, 64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (pronto) pulses++;
        end
        chk("mrst_no_pronto", 64'(pulses), 64'd0);
        chk("mrst_idle", {63'b0, ocupado}, 64'd0);
        run_op("multu_3x5", 3'b000, 32'd3, 32'd5, 32'd0, 32'd15);

        run_op("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m3x5", 3'b001, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_m4xm6", 3'b001, 32'hFFFF_FFFC, 32'hFFFF_FFFA,
               32'd0, 32'd24);
        run_op("div_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2", 3'b010, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div_min_m1", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000);
        run_op("divu_big", 3'b010, 32'hFFFF_FFFF, 32'd10,
               32'd5, 32'h1999_9999);

        // Division by zero
        run_op("divu_5_0", 3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        chk("dz_set", {63'b0, div_por_zero}, 64'd1);
        repeat (3) @(posedge clock);
        #1;
        chk("dz_hold", {63'b0, div_por_zero}, 64'd1);
        mtx(1'b0, 32'h0000_00AB);
        chk("dz_mtx", {63'b0, div_por_zero}, 64'd1);
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = 3'b000;
        operando_a = 32'd2;
        operando_b = 32'd2;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        chk("dz_clear", {63'b0, div_por_zero}, 64'd0);
        wait_done(n);
        chk("dz_mul_lo", {32'b0, lo}, 64'd4);
        run_op("div_m9_0", 3'b011, 32'hFFFF_FFF7, 32'd0,
               32'hFFFF_FFF7, 32'hFFFF_FFFF);
        chk("dz_signed", {63'b0, div_por_zero}, 64'd1);

        // MTHI then MTLO back to back
        lo_prev = lo;
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = 3'b100;
        operando_a = 32'h1234_5678;
        @(posedge clock);
        #1;
        chk("mthi_hi", {32'b0, hi}, 64'h1234_5678);
        chk("mthi_lo", {32'b0, lo}, {32'b0, lo_prev});
        chk("mthi_pronto", {63'b0, pronto}, 64'd1);
        chk("mthi_busy", {63'b0, ocupado}, 64'd0);
        operacao   = 3'b101;
        operando_a = 32'hCAFE_BABE;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        chk("mtlo_lo", {32'b0, lo}, 64'hCAFE_BABE);
        chk("mtlo_hi", {32'b0, hi}, 64'h1234_5678);
        chk("mtlo_pronto", {63'b0, pronto}, 64'd1);
        @(posedge clock);
        #1;
        chk("mtx_pulse", {63'b0, pronto}, 64'd0);

        // Reserved opcode is ignored
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = 3'b110;
        operando_a = 32'h0BAD_0BAD;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        chk("rsv_busy", {63'b0, ocupado}, 64'd0);
        chk("rsv_pronto", {63'b0, pronto}, 64'd0);
        chk("rsv_hi", {32'b0, hi}, 64'h1234_5678);
        chk("rsv_lo", {32'b0, lo}, 64'hCAFE_BABE);

        // MTLO while busy is dropped
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = 3'b000;
        operando_a = 32'd2;
        operando_b = 32'd3;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        inicio     = 1'b1;
        operacao   = 3'b101;
        operando_a = 32'h0000_DEAD;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        chk("busy_mtlo_lo", {32'b0, lo}, 64'hCAFE_BABE);
        chk("busy_mtlo_pronto", {63'b0, pronto}, 64'd0);
        chk("busy_mtlo_busy", {63'b0, ocupado}, 64'd1);
        wait_done(n);
        chk("busy_lat", 64'(n), 64'd28);
        chk("busy_lo", {32'b0, lo}, 64'd6);
        chk("busy_hi", {32'b0, hi}, 64'd0);

        // inicio held in the pronto cycle starts the next op
        operacao   = 3'b000;
        operando_a = 32'd4;
        operando_b = 32'd4;
        inicio     = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        chk("b2b_busy", {63'b0, ocupado}, 64'd1);
        chk("b2b_pronto", {63'b0, pronto}, 64'd0);
        wait_done(n);
        chk("b2b_lat", 64'(n), 64'd33);
        chk("b2b_lo", {32'b0, lo}, 64'd16);

        hi_prev = hi;
        lo_prev = lo;
        repeat (5) @(posedge clock);
        #1;
        chk("hold_hi", {32'b0, hi}, {32'b0, hi_prev});
        chk("hold_lo", {32'b0, lo}, {32'b0, lo_prev});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
